// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-granular round-robin arbiter that shares one
// AXI4-Stream video sink between N_SRC sources. user marks SOF, last marks EOL.
// A grant lasts exactly LINES_PER_FRAME lines. Beats that arrive between frames
// from sources that are not starting a frame are discarded and counted.
//
// Handshake: a beat moves on any port only when valid && ready are both high in
// the same cycle. Valid never depends on ready. Inside a frame, sink ready is
// passed combinationally to the granted source. Sink valid, data, last and user
// are copies of that source's signals.
module axis_frame_arbiter #(
  parameter int N_SRC           = 2,
  parameter int DATA_BITS       = 8,
  parameter int LINES_PER_FRAME = 4,
  parameter int DROP_CNT_BITS   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_SRC*DATA_BITS-1:0]   axis_s_data_i,
  input  logic [N_SRC-1:0]             axis_s_valid_i,
  output logic [N_SRC-1:0]             axis_s_ready_o,
  input  logic [N_SRC-1:0]             axis_s_last_i,
  input  logic [N_SRC-1:0]             axis_s_user_i,
  output logic [DATA_BITS-1:0]         axis_m_data_o,
  output logic                         axis_m_valid_o,
  input  logic                         axis_m_ready_i,
  output logic                         axis_m_last_o,
  output logic                         axis_m_user_o,
  output logic [N_SRC-1:0]             grant_o,
  output logic                         busy_o,
  output logic                         frame_err_o,
  output logic [DROP_CNT_BITS-1:0]     drop_cnt_o
);

  localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int SUM_W  = DROP_CNT_BITS + 4;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [PTR_W-1:0]  LAST_SRC  = PTR_W'(N_SRC - 1);
  localparam logic [SUM_W-1:0]  DROP_MAX  = {4'b0, {DROP_CNT_BITS{1'b1}}};

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                   state;
  logic [N_SRC-1:0]         grant;
  logic [PTR_W-1:0]         gidx;
  logic [PTR_W-1:0]         rr_ptr;
  logic [LINE_W-1:0]        line_cnt;
  logic                     first_beat;
  logic [DROP_CNT_BITS-1:0] drop_cnt;
  logic                     frame_err;

  logic [DATA_BITS-1:0]     src_data [N_SRC];
  logic                     sof_found;
  logic [PTR_W-1:0]         sof_sel;
  logic [N_SRC-1:0]         sof_onehot;
  logic [N_SRC-1:0]         drop_vec;
  logic [SUM_W-1:0]         drop_sum;
  logic [DROP_CNT_BITS-1:0] drop_next;
  logic                     beat_acc;
  logic                     mid_sof;
  logic                     frame_done;

  // Split the packed source data bus into one lane per source
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_data[i] = axis_s_data_i[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Round-robin search for the first SOF requester starting at rr_ptr
  always_comb begin
    logic [PTR_W:0]   sum_idx;
    logic [PTR_W-1:0] idx;
    sof_found  = 1'b0;
    sof_sel    = '0;
    sof_onehot = '0;
    sum_idx    = '0;
    idx        = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sum_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum_idx >= (PTR_W+1)'(N_SRC)) sum_idx = sum_idx - (PTR_W+1)'(N_SRC);
      idx = sum_idx[PTR_W-1:0];
      if (!sof_found && axis_s_valid_i[idx] && axis_s_user_i[idx]) begin
        sof_found = 1'b1;
        sof_sel   = idx;
      end
    end
    sof_onehot[sof_sel] = 1'b1;
  end

  // Handshake routing: drop non-SOF beats when idle, pass through when granted
  always_comb begin
    axis_s_ready_o = '0;
    axis_m_valid_o = 1'b0;
    drop_vec       = '0;
    if (!rst_i) begin
      if (state == ST_IDLE) begin
        drop_vec       = axis_s_valid_i & ~axis_s_user_i;
        axis_s_ready_o = drop_vec;
      end else begin
        axis_m_valid_o       = axis_s_valid_i[gidx];
        axis_s_ready_o[gidx] = axis_m_ready_i;
      end
    end
  end

  // Saturating add of this cycle's dropped beats
  always_comb begin
    drop_sum = {4'b0, drop_cnt};
    for (int i = 0; i < N_SRC; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    end
    drop_next = (drop_sum > DROP_MAX) ? {DROP_CNT_BITS{1'b1}} : drop_sum[DROP_CNT_BITS-1:0];
  end

  assign axis_m_data_o = src_data[gidx];
  assign axis_m_last_o = axis_s_last_i[gidx];
  assign axis_m_user_o = axis_s_user_i[gidx];

  // A mid-frame SOF restarts the line count; with last set it completes line 0
  assign beat_acc   = (state == ST_GRANT) && axis_s_valid_i[gidx] && axis_m_ready_i;
  assign mid_sof    = beat_acc && axis_s_user_i[gidx] && !first_beat;
  assign frame_done = beat_acc && axis_s_last_i[gidx] &&
                      (mid_sof ? (LINES_PER_FRAME == 1) : (line_cnt == LAST_LINE));

  // Frame FSM: grant, round-robin pointer, line counter, error pulse, drop count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      grant      <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      line_cnt   <= '0;
      first_beat <= 1'b0;
      drop_cnt   <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= mid_sof;
      drop_cnt  <= drop_next;
      case (state)
        ST_IDLE: begin
          if (sof_found) begin
            state      <= ST_GRANT;
            grant      <= sof_onehot;
            gidx       <= sof_sel;
            line_cnt   <= '0;
            first_beat <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (beat_acc) begin
            first_beat <= 1'b0;
            if (frame_done) begin
              state    <= ST_IDLE;
              grant    <= '0;
              line_cnt <= '0;
              rr_ptr   <= (gidx == LAST_SRC) ? '0 : gidx + PTR_W'(1);
            end else if (mid_sof) begin
              line_cnt <= axis_s_last_i[gidx] ? LINE_W'(1) : '0;
            end else if (axis_s_last_i[gidx]) begin
              line_cnt <= line_cnt + LINE_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o     = grant;
  assign busy_o      = (state == ST_GRANT);
  assign frame_err_o = frame_err;
  assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: single-source frame, resync drops,
// round-robin order, backpressure, mid-frame SOF, reset mid-frame, saturation.
module tb_axis_frame_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Main instance signals
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_valid, s_ready, s_last, s_user;
  logic [DW-1:0]   m_data;
  logic            m_valid, m_ready, m_last, m_user;
  logic [N-1:0]    grant;
  logic            busy, ferr;
  logic [15:0]     drop;

  // Saturation instance signals
  logic [N*DW-1:0] z_s_data;
  logic [N-1:0]    z_s_valid, z_s_ready, z_s_last, z_s_user;
  logic [DW-1:0]   z_m_data;
  logic            z_m_valid, z_m_ready, z_m_last, z_m_user;
  logic [N-1:0]    z_grant;
  logic            z_busy, z_ferr;
  logic [1:0]      z_drop;

  int checks = 0;
  int errors = 0;

  axis_frame_arbiter #(.N_SRC(N), .DATA_BITS(DW), .LINES_PER_FRAME(4), .DROP_CNT_BITS(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .axis_s_data_i(s_data), .axis_s_valid_i(s_valid), .axis_s_ready_o(s_ready),
    .axis_s_last_i(s_last), .axis_s_user_i(s_user),
    .axis_m_data_o(m_data), .axis_m_valid_o(m_valid), .axis_m_ready_i(m_ready),
    .axis_m_last_o(m_last), .axis_m_user_o(m_user),
    .grant_o(grant), .busy_o(busy), .frame_err_o(ferr), .drop_cnt_o(drop)
  );

  axis_frame_arbiter #(.N_SRC(N), .DATA_BITS(DW), .LINES_PER_FRAME(4), .DROP_CNT_BITS(2)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .axis_s_data_i(z_s_data), .axis_s_valid_i(z_s_valid), .axis_s_ready_o(z_s_ready),
    .axis_s_last_i(z_s_last), .axis_s_user_i(z_s_user),
    .axis_m_data_o(z_m_data), .axis_m_valid_o(z_m_valid), .axis_m_ready_i(z_m_ready),
    .axis_m_last_o(z_m_last), .axis_m_user_o(z_m_user),
    .grant_o(z_grant), .busy_o(z_busy), .frame_err_o(z_ferr), .drop_cnt_o(z_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk(input int k, input int fr, input int b);
    return {k[0], fr[1:0], b[4:0]};
  endfunction

  task automatic set_src(input int k, input logic v, input logic [DW-1:0] d, input logic l, input logic u);
    s_valid[k]          = v;
    s_data[k*DW +: DW]  = d;
    s_last[k]           = l;
    s_user[k]           = u;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One IDLE arbitration cycle followed by a frame from source k.
  // Lines are 4 beats; user on beat 0 and on beat sof2; abort_at asserts reset.
  task automatic run_frame(input int k, input int fr, input int nbeats, input int sof2,
                           input bit other_req, input bit rand_rdy, input int abort_at);
    int   o, b, cyc;
    logic acc, exp_err;
    o = 1 - k;
    set_src(k, 1'b1, mk(k, fr, 0), 1'b0, 1'b1);
    if (other_req) set_src(o, 1'b1, mk(o, 0, 0), 1'b0, 1'b1);
    else           set_src(o, 1'b0, '0, 1'b0, 1'b0);
    m_ready = 1'b1;
    @(negedge clk);
    check("idle_m_valid", m_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("idle_sof_held", s_ready, 0);
    check("idle_frame_err", ferr, 0);
    step();
    b = 0; cyc = 0; exp_err = 1'b0;
    while (b < nbeats && cyc < 200) begin
      cyc++;
      set_src(k, 1'b1, mk(k, fr, b), (b % 4) == 3, (b == 0) || (b == sof2));
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        step();
        rst = 1'b0;
        set_src(k, 1'b0, '0, 1'b0, 1'b0);
        set_src(o, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_grant", grant, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_m_valid", m_valid, 0);
        check("post_rst_drop", drop, 0);
        check("post_rst_frame_err", ferr, 0);
        step();
        return;
      end
      @(negedge clk);
      check("grant", grant, 1 << k);
      check("busy", busy, 1);
      check("m_valid", m_valid, 1);
      check("m_data", m_data, mk(k, fr, b));
      check("m_last", m_last, (b % 4) == 3);
      check("m_user", m_user, (b == 0) || (b == sof2));
      check("s_ready", s_ready, m_ready ? (1 << k) : 0);
      check("frame_err", ferr, exp_err);
      acc = m_ready;
      step();
      if (acc) begin
        exp_err = (b == sof2) && (b != 0);
        b++;
      end else begin
        exp_err = 1'b0;
      end
    end
    check("frame_beats", b, nbeats);
    set_src(k, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_data = '0; s_valid = 2'b01; s_last = '0; s_user = '0; m_ready = 1'b1;
    z_s_data = '0; z_s_valid = '0; z_s_last = '0; z_s_user = '0; z_m_ready = 1'b1;

    // Reset: handshakes held off while rst is high
    @(negedge clk);
    check("rst_hold_s_ready", s_ready, 0);
    check("rst_hold_m_valid", m_valid, 0);
    step();
    rst = 1'b0;
    s_valid = '0;
    @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", drop, 0);
    check("reset_frame_err", ferr, 0);
    check("reset_sat_drop", z_drop, 0);
    step();

    // Single source frame, then the frame-end bubble
    run_frame(0, 0, 16, -1, 1'b0, 1'b0, -1);
    @(negedge clk);
    check("bubble_busy", busy, 0);
    check("bubble_grant", grant, 0);
    check("bubble_m_valid", m_valid, 0);
    step();

    // Resync: five junk beats from source 1 are dropped
    for (int i = 0; i < 5; i++) begin
      set_src(1, 1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
      @(negedge clk);
      check("junk_s_ready", s_ready, 2'b10);
      check("junk_m_valid", m_valid, 0);
      check("junk_drop_before", drop, i);
      step();
    end
    set_src(1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("drop_count_5", drop, 5);
    step();
    run_frame(1, 0, 16, -1, 1'b0, 1'b0, -1);

    // Round-robin with both sources requesting: order 0,1,0,1
    run_frame(0, 1, 16, -1, 1'b1, 1'b0, -1);
    run_frame(1, 1, 16, -1, 1'b1, 1'b0, -1);
    run_frame(0, 2, 16, -1, 1'b1, 1'b0, -1);
    run_frame(1, 2, 16, -1, 1'b0, 1'b0, -1);

    // Backpressure on the sink
    run_frame(0, 3, 16, -1, 1'b0, 1'b1, -1);

    // Mid-frame SOF on beat 6: four more EOLs from there, 20 beats total
    run_frame(0, 0, 20, 6, 1'b0, 1'b0, -1);
    check("mid_sof_drop_unchanged", drop, 5);

    // Reset on beat 9, then source 1 alone is granted
    run_frame(0, 1, 16, -1, 1'b0, 1'b0, 9);
    run_frame(1, 3, 16, -1, 1'b0, 1'b0, -1);

    // Drop counter saturation on the 2-bit instance: 2 beats per cycle
    z_s_valid = 2'b11;
    @(negedge clk);
    check("sat_s_ready", z_s_ready, 2'b11);
    check("sat_drop_0", z_drop, 0);
    step();
    @(negedge clk);
    check("sat_drop_2", z_drop, 2);
    step();
    @(negedge clk);
    check("sat_drop_3", z_drop, 3);
    step();
    z_s_valid = 2'b00;
    @(negedge clk);
    check("sat_drop_hold", z_drop, 3);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
